// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard for the 4-slot VLIW issue stage: tracks busy destinations
// and raises a RAW/WAW stall. Optional writeback bypass: `define SCOREBOARD_WB_BYPASS_EN.
module issue_scoreboard #(
  parameter int unsigned NREG = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic [6:0]      iss_rd1,
  input  logic [6:0]      iss_rd2,
  input  logic [6:0]      iss_rd3,
  input  logic [6:0]      iss_rd4,
  input  logic [6:0]      iss_rs1a,
  input  logic [6:0]      iss_rs1b,
  input  logic [6:0]      iss_rs2a,
  input  logic [6:0]      iss_rs2b,
  input  logic [6:0]      iss_rs3a,
  input  logic [6:0]      iss_rs3b,
  input  logic [6:0]      iss_rs4a,
  input  logic [6:0]      iss_rs4b,
  input  logic [6:0]      wb_rd1,
  input  logic [6:0]      wb_rd2,
  input  logic [6:0]      wb_rd3,
  input  logic [6:0]      wb_rd4,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic [7:0]      outstanding,
  output logic            idle
);

  logic [6:0] rd [4];
  logic [6:0] rs [8];
  logic [6:0] wb [4];

  assign rd[0] = iss_rd1;
  assign rd[1] = iss_rd2;
  assign rd[2] = iss_rd3;
  assign rd[3] = iss_rd4;
  assign rs[0] = iss_rs1a;
  assign rs[1] = iss_rs1b;
  assign rs[2] = iss_rs2a;
  assign rs[3] = iss_rs2b;
  assign rs[4] = iss_rs3a;
  assign rs[5] = iss_rs3b;
  assign rs[6] = iss_rs4a;
  assign rs[7] = iss_rs4b;
  assign wb[0] = wb_rd1;
  assign wb[1] = wb_rd2;
  assign wb[2] = wb_rd3;
  assign wb[3] = wb_rd4;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wb_mask, iss_mask, busy_eff;
  logic [7:0]      cnt_q, cnt_d;
  logic            idle_q;
  logic            hazard, accept;

  // Index 0 is the "no register" code and never enters either mask.
  always_comb begin
    wb_mask  = '0;
    iss_mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (wb[i] != 7'd0) wb_mask[wb[i]] = 1'b1;
      if (rd[i] != 7'd0) iss_mask[rd[i]] = 1'b1;
    end
  end

  always_comb begin
`ifdef SCOREBOARD_WB_BYPASS_EN
    // Retiring registers are readable this cycle via register-file write-through.
    busy_eff = busy_q & ~wb_mask;
`else
    busy_eff = busy_q;
`endif
    busy_eff[0] = 1'b0;
  end

  // In-bundle source/destination matches are deliberately ignored: slots read old values.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 4; i++) hazard = hazard | busy_eff[rd[i]];
    for (int j = 0; j < 8; j++) hazard = hazard | busy_eff[rs[j]];
  end

  assign stall  = issue_valid & hazard;
  assign accept = issue_valid & ~stall & ~flush;

  // Clear first, then set, so a same-cycle set of the same index wins.
  always_comb begin
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = (busy_q & ~wb_mask) | (accept ? iss_mask : '0);
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++) cnt_d = cnt_d + 8'(busy_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      idle_q <= (cnt_d == 8'd0);
    end
  end

  assign busy_vec    = busy_q;
  assign outstanding = cnt_q;
  assign idle        = idle_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed and randomized bench for issue_scoreboard, checked against a set-based
// model of pending destination registers.
module tb_issue_scoreboard;

  logic         clk = 1'b0;
  logic         rst, flush, issue_valid;
  logic [6:0]   rd [4];
  logic [6:0]   rs [8];
  logic [6:0]   wb [4];
  logic         stall;
  logic [127:0] busy_vec;
  logic [7:0]   outstanding;
  logic         idle;

  int checks   = 0;
  int failures = 0;

  // Model: the set of register indices with a write still pending.
  bit pend [int];

  always #5 clk = ~clk;

  issue_scoreboard #(.NREG(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .iss_rd1     (rd[0]),
    .iss_rd2     (rd[1]),
    .iss_rd3     (rd[2]),
    .iss_rd4     (rd[3]),
    .iss_rs1a    (rs[0]),
    .iss_rs1b    (rs[1]),
    .iss_rs2a    (rs[2]),
    .iss_rs2b    (rs[3]),
    .iss_rs3a    (rs[4]),
    .iss_rs3b    (rs[5]),
    .iss_rs4a    (rs[6]),
    .iss_rs4b    (rs[7]),
    .wb_rd1      (wb[0]),
    .wb_rd2      (wb[1]),
    .wb_rd3      (wb[2]),
    .wb_rd4      (wb[3]),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .outstanding (outstanding),
    .idle        (idle)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit retiring(input logic [6:0] r);
    for (int i = 0; i < 4; i++) if (wb[i] != 7'd0 && wb[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit reg_blocks(input logic [6:0] r);
    if (r == 7'd0 || !pend.exists(int'(r))) return 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (retiring(r)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_stall();
    if (!issue_valid) return 1'b0;
    for (int i = 0; i < 4; i++) if (reg_blocks(rd[i])) return 1'b1;
    for (int j = 0; j < 8; j++) if (reg_blocks(rs[j])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [127:0] model_vec();
    logic [127:0] v = '0;
    foreach (pend[k]) v[k] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    logic es;
    es = exp_stall();
    if (rst || flush) begin
      pend.delete();
    end else begin
      for (int i = 0; i < 4; i++) if (wb[i] != 7'd0) pend.delete(int'(wb[i]));
      if (issue_valid && !es)
        for (int i = 0; i < 4; i++) if (rd[i] != 7'd0) pend[int'(rd[i])] = 1'b1;
    end
  endtask

  task automatic quiet();
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin rd[i] = 7'd0; wb[i] = 7'd0; end
    for (int j = 0; j < 8; j++) rs[j] = 7'd0;
  endtask

  // Inputs are driven just after a rising edge; comb stall and registered state are
  // sampled 1 ns later and 1 ns after the next edge respectively.
  task automatic cycle();
    #1;
    check("stall", 128'(stall), 128'(exp_stall()));
    model_step();
    @(posedge clk);
    #1;
    check("busy_vec", busy_vec, model_vec());
    check("outstanding", 128'(outstanding), 128'(pend.num()));
    check("idle", 128'(idle), 128'(pend.num() == 0));
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    check("reset_busy", busy_vec, 128'd0);
    check("reset_outstanding", 128'(outstanding), 128'd0);
    check("reset_idle", 128'(idle), 128'd1);

    // First issue after reset.
    quiet(); issue_valid = 1'b1; rd[0] = 7'd5;
    #1 check("first_issue_stall", 128'(stall), 128'd0);
    cycle();
    check("first_busy5", 128'(busy_vec[5]), 128'd1);
    check("first_outstanding", 128'(outstanding), 128'd1);
    check("first_idle", 128'(idle), 128'd0);

    // RAW on slot 2 source a, held until register 5 retires.
    quiet(); issue_valid = 1'b1; rs[2] = 7'd5;
    #1 check("raw_stall", 128'(stall), 128'd1);
    cycle();
    cycle();
    wb[2] = 7'd5;
`ifdef SCOREBOARD_WB_BYPASS_EN
    #1 check("raw_wb_cycle", 128'(stall), 128'd0);
`else
    #1 check("raw_wb_cycle", 128'(stall), 128'd1);
`endif
    cycle();
    wb[2] = 7'd0;
    #1 check("raw_after_wb", 128'(stall), 128'd0);
    cycle();

    // WAW against a busy register.
    quiet(); issue_valid = 1'b1; rd[0] = 7'd70;
    cycle();
    quiet(); issue_valid = 1'b1; rd[3] = 7'd70;
    #1 check("waw_stall", 128'(stall), 128'd1);
    cycle();
    // Source equal to an in-bundle destination is not a hazard.
    quiet(); issue_valid = 1'b1; rd[0] = 7'd9; rs[0] = 7'd9;
    #1 check("inbundle_nostall", 128'(stall), 128'd0);
    cycle();
    // Index 0 never stalls and is never marked busy.
    quiet(); issue_valid = 1'b1;
    #1 check("zero_nostall", 128'(stall), 128'd0);
    cycle();
    check("busy0", 128'(busy_vec[0]), 128'd0);

    // Set wins over clear on the same index.
    quiet(); issue_valid = 1'b1; wb[0] = 7'd12; rd[1] = 7'd12;
    cycle();
    check("collision_busy12", 128'(busy_vec[12]), 128'd1);
    // Duplicate destinations counted once, freed by one writeback.
    quiet(); issue_valid = 1'b1; rd[0] = 7'd20; rd[2] = 7'd20;
    cycle();
    check("dup_busy20", 128'(busy_vec[20]), 128'd1);
    check("dup_outstanding", 128'(outstanding), 128'd4);
    quiet(); wb[1] = 7'd20;
    cycle();
    check("dup_freed20", 128'(busy_vec[20]), 128'd0);

    // Flush beats both writeback clear and issue set.
    quiet(); flush = 1'b1; issue_valid = 1'b1; rd[0] = 7'd33; wb[0] = 7'd70;
    cycle();
    check("flush_busy", busy_vec, 128'd0);
    check("flush_outstanding", 128'(outstanding), 128'd0);
    check("flush_idle", 128'(idle), 128'd1);

    // Full scale: 124 distinct destinations, then reset mid-stream.
    for (int b = 0; b < 31; b++) begin
      quiet(); issue_valid = 1'b1;
      for (int i = 0; i < 4; i++) rd[i] = 7'(4 * b + i + 1);
      cycle();
    end
    check("full_outstanding", 128'(outstanding), 128'd124);
    quiet(); rst = 1'b1; issue_valid = 1'b1; rd[0] = 7'd125;
    cycle();
    check("rst_outstanding", 128'(outstanding), 128'd0);
    quiet(); issue_valid = 1'b1; rd[0] = 7'd3;
    cycle();
    quiet(); wb[0] = 7'd127;
    cycle();
    check("clear_unset_outstanding", 128'(outstanding), 128'd1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      quiet();
      issue_valid = ($urandom_range(3) != 0);
      flush       = ($urandom_range(31) == 0);
      rst         = ($urandom_range(63) == 0);
      for (int i = 0; i < 4; i++) begin
        rd[i] = 7'($urandom_range(15));
        wb[i] = ($urandom_range(1) == 0) ? 7'($urandom_range(15)) : 7'd0;
      end
      for (int j = 0; j < 8; j++) rs[j] = ($urandom_range(2) == 0) ? 7'($urandom_range(15)) : 7'd0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
